rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback sources: the in-order pipeline W path, the multi-cycle mul/div unit and the CSR unit.
- Round-robin arbitration with a valid/ready handshake per source.
- The winner's control packet and data are registered into the RF write port, so output timing is identical to the existing W-stage register.
- Sits between the W stage / functional units and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- N_BITS, from core_types_pkg (32), data width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-source write request.
- req_ready  output  NUM_REQ  per-source grant; a transfer occurs when valid & ready are both high in the same cycle.
- req_ctrl  input  NUM_REQ x $bits(rf_wb_ctrl_t)  per-source packet; rf_wb_ctrl_t = {wen, waddr[4:0]}.
- req_data  input  NUM_REQ x N_BITS  per-source write data.
- rf_wb_ctrl_out  output  $bits(rf_wb_ctrl_t)  registered packet to the RF.
- data_out  output  N_BITS  registered write data to the RF.
- grant_id  output  $clog2(NUM_REQ)  registered index of the source that produced the current output (debug/perf).

Behaviour:
- Reset (rst_n low at a clk edge):
  - rr_ptr=0, rf_wb_ctrl_out=0 (wen=0), data_out=0, grant_id=0.
  - req_ready is forced to all-zero while rst_n is low.
- Arbitration is combinational in the request cycle:
  - Search req_valid starting at index rr_ptr, ascending, wrapping at NUM_REQ-1 -> 0.
  - The first valid index wins; req_ready is one-hot on the winner, zero elsewhere.
  - No valid request -> req_ready=0.
- req_ready never depends on req_ctrl or req_data. It depends only on req_valid, rr_ptr and rst_n.
- On a transfer from source i:
  - Next cycle, rf_wb_ctrl_out=req_ctrl[i], data_out=req_data[i], grant_id=i (latency 1).
  - rr_ptr <= (i+1) mod NUM_REQ.
- No transfer:
  - Next cycle, rf_wb_ctrl_out.wen=0; waddr and data_out hold their previous values.
  - rr_ptr and grant_id hold.
- x0 suppression: if the accepted packet has waddr==0, the registered wen is 0. The transfer still counts for rr_ptr.
- A request with wen=0 is arbitrated and accepted like any other and occupies one slot.
- Source protocol:
  - Once asserted, req_valid/ctrl/data hold stable until accepted.
  - The arbiter need not tolerate withdrawal; the bench asserts this.
- Fairness: a continuously valid source is granted within NUM_REQ cycles.
- Throughput: one write per cycle when any source is valid. No bubbles between back-to-back transfers.
- Single requester alone: granted every cycle it is valid.
- Reset mid-operation:
  - Outputs and rr_ptr return to reset values at that edge.
  - A request pending at reset is not transferred and no RF write is emitted for it.
- Two sources writing the same waddr in consecutive cycles: both are emitted in grant order; no merging or reordering.

Decomposition:
- core_types_pkg: rf_wb_ctrl_t (already present), N_BITS, and a new WB_NUM_REQ constant plus source-index localparams WB_SRC_PIPE=0, WB_SRC_MDU=1, WB_SRC_CSR=2.
- Sub-module rr_arb (parameter N): combinational rotating-priority arbiter.
  - Inputs: req[N], ptr.
  - Outputs: gnt one-hot, gnt_idx, any.
  - Implemented as a doubled-vector priority encode.
- Output registers: dl_reg_en_rst instances.
  - Data: en = transfer.
  - Ctrl: always enabled, with the transfer/x0-gated wen.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=000, wen=0, data_out=0, grant_id=0; release -> the first grant goes to source 0.
- Single source: src1 valid with {wen=1, waddr=5}, data 0xDEADBEEF -> ready[1] the same cycle; the next cycle shows wen=1, waddr=5, data_out=0xDEADBEEF, grant_id=1; then wen=0 once valid drops.
- Round-robin under saturation: all 3 sources continuously valid, each presenting a new packet after every acceptance -> grant order 0,1,2,0,1,2; one write every cycle; no source waits more than 3 cycles.
- Pointer wrap: rr_ptr=2 with only src0 and src1 valid -> src0 wins, then src1, then rr_ptr=2.
- x0 write: src2 with {wen=1, waddr=0}, data 0x1234 -> ready[2]=1, next-cycle wen=0, rr_ptr advances to 0.
- Reset mid-stream: assert rst_n=0 the cycle after src0 is accepted -> the output is already emitted, then it clears to wen=0 at the reset edge; the pending src1 request produces no write until rst_n returns high.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Purpose: shared types and constants for the register-file writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_wb_arbiter_pkg;

  localparam int N_BITS     = 32;  // RF data width
  localparam int WB_NUM_REQ = 3;   // writeback sources sharing the RF write port

  // Source indices into the arbiter request vectors
  localparam int WB_SRC_PIPE = 0;  // in-order pipeline W stage
  localparam int WB_SRC_MDU  = 1;  // multi-cycle mul/div unit
  localparam int WB_SRC_CSR  = 2;  // CSR unit

  // Control packet carried to the RF write port
  typedef struct packed {
    logic       wen;
    logic [4:0] waddr;
  } rf_wb_ctrl_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb.sv
// Purpose: combinational rotating-priority (round-robin) arbiter.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports:
//   req     - request vector, one bit per source
//   ptr     - highest-priority index for this cycle (must be < N)
//   gnt     - one-hot grant, zero when nothing is requested
//   gnt_idx - binary index of the granted source
//   any     - at least one request is present
module rr_arb #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Two copies of the request vector back to back: scanning the window
  // [ptr, ptr+N) ascending is a wrap-around search starting at ptr.
  logic [2*N-1:0] dbl;

  assign dbl = {req, req};

  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!any && dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + N)) begin
        any     = 1'b1;
        gnt_idx = (j >= N) ? IW'(j - N) : IW'(j);
      end
    end
    gnt = '0;
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: round-robin share of the single RF write port among NUM_REQ writeback sources.
// Latency: 1 cycle from the valid&ready transfer to the registered RF write outputs.
// Backpressure: one source is granted per cycle via req_ready; losers hold their request.
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   req_valid/ready - per-source handshake; transfer when both are high
//   req_ctrl/data   - per-source {wen, waddr} packet and write data
//   rf_wb_ctrl_out  - registered packet to the RF (wen low when idle or waddr==0)
//   data_out        - registered write data to the RF
//   grant_id        - registered index of the source behind the current output
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = WB_NUM_REQ,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  rf_wb_ctrl_t [NUM_REQ-1:0]        req_ctrl,
  input  logic [NUM_REQ-1:0][N_BITS-1:0]   req_data,
  output rf_wb_ctrl_t                      rf_wb_ctrl_out,
  output logic [N_BITS-1:0]                data_out,
  output logic [IW-1:0]                    grant_id
);

  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  rf_wb_ctrl_t         ctrl_q, ctrl_d;
  logic [N_BITS-1:0]   data_q, data_d;
  logic [IW-1:0]       gid_q, gid_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_idx;
  logic                any;
  logic                xfer;
  rf_wb_ctrl_t         sel_ctrl;

  rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Grants are suppressed in reset so a pending request is never consumed.
  assign req_ready = gnt & {NUM_REQ{rst_n}};
  assign xfer      = any & rst_n;
  assign sel_ctrl  = req_ctrl[gnt_idx];

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    ctrl_d       = ctrl_q;
    ctrl_d.wen   = 1'b0;    // idle cycles never write; waddr holds
    data_d       = data_q;
    gid_d        = gid_q;
    if (xfer) begin
      ctrl_d.waddr = sel_ctrl.waddr;
      // x0 is hardwired zero: accept the write but never assert wen for it
      ctrl_d.wen   = sel_ctrl.wen && (sel_ctrl.waddr != 5'd0);
      data_d       = req_data[gnt_idx];
      gid_d        = gnt_idx;
      rr_ptr_d     = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      ctrl_q   <= '0;
      data_q   <= '0;
      gid_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
    end
  end

  assign rf_wb_ctrl_out = ctrl_q;
  assign data_out       = data_q;
  assign grant_id       = gid_q;

endmodule
